// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   RV_NOP           : instruction word presented while no valid instruction is available
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one fetch queue slot {pc, data, data_ok}
package fetch_pkg;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        data_ok;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory channel: valid/ready request plus in-order response.
//   imem_req_valid / imem_req_addr / imem_req_ready : request handshake
//   imem_rsp_valid / imem_rsp_data                  : response, no backpressure
// master = fetch unit side, slave = memory side.
interface instruction_fetch_unit_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

endinterface

// File: rtl/instruction_fetch_unit_queue.sv
// In-order circular fetch queue of DEPTH entries.
//   clear_i                : drop all entries (has priority over other operations)
//   alloc_i / alloc_pc_i   : allocate tail entry with pc, data_ok=0
//   fill_i / fill_data_i   : write data into the oldest entry still awaiting data
//   pop_i                  : remove head entry
//   head_o                 : head entry (data_ok is 0 whenever the queue is empty)
//   count_o / pending_o    : occupancy and number of entries awaiting data
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   alloc_i,
    input  logic [31:0]            alloc_pc_i,
    input  logic                   fill_i,
    input  logic [31:0]            fill_data_i,
    input  logic                   pop_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] pending_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   entries_q [DEPTH];
    fetch_entry_t   entries_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  pending_q, pending_d;
    logic [PW-1:0]  fill_idx;

    // Fills are in order, so unfilled entries are always the youngest ones:
    // the oldest unfilled entry sits just past the filled ones.
    assign fill_idx  = rd_ptr_q + PW'(count_q - pending_q);
    assign head_o    = entries_q[rd_ptr_q];
    assign count_o   = count_q;
    assign pending_o = pending_q;

    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pending_d = pending_q;
        if (clear_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].data_ok = 1'b0;
            end
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            pending_d = '0;
        end else begin
            // data_ok is cleared on pop so an empty queue never shows a valid head.
            if (pop_i) begin
                entries_d[rd_ptr_q].data_ok = 1'b0;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (fill_i) begin
                entries_d[fill_idx].data    = fill_data_i;
                entries_d[fill_idx].data_ok = 1'b1;
            end
            // Applied after pop: a full queue may pop and reuse that slot in one cycle.
            if (alloc_i) begin
                entries_d[wr_ptr_q] = fetch_entry_t'{pc: alloc_pc_i, data: '0, data_ok: 1'b0};
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d   = count_q + CW'(alloc_i) - CW'(pop_i);
            pending_d = pending_q + CW'(alloc_i) - CW'(fill_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, buffers
// responses in order and presents instruction/pc_count to the decoder.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   fetch_en                   : allow new fetch requests
//   imem (master)              : memory request/response channel
//   redirect_valid/redirect_pc : taken branch/jump, flushes queue and in-flight fetches
//   out_valid/out_ready        : decoder handshake
//   instruction/pc_count       : head instruction word and its PC
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            fetch_en,
    instruction_fetch_unit_if.master        imem,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_pc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     instruction,
    output logic [31:0]                     pc_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          run_q;

    fetch_entry_t  head;
    logic [CW-1:0] q_count, q_pending;
    logic          req_valid, accept, pop, fill;
    logic [SW-1:0] used, owed;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (redirect_valid),
        .alloc_i     (accept),
        .alloc_pc_i  (fetch_pc_q),
        .fill_i      (fill),
        .fill_data_i (imem.imem_rsp_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (q_count),
        .pending_o   (q_pending)
    );

    always_comb begin
        out_valid = head.data_ok & ~redirect_valid;
        pop       = out_valid & out_ready;
        // A slot freed by this cycle's pop may be reused by this cycle's request,
        // which is what sustains one instruction per cycle at DEPTH=2.
        used      = SW'(q_count) - SW'(pop) + SW'(discard_q);
        req_valid = run_q & fetch_en & ~redirect_valid & (used < SW'(DEPTH));
        accept    = req_valid & imem.imem_req_ready;
        // Responses with nothing outstanding are ignored (pending==0, discard==0).
        fill      = imem.imem_rsp_valid & ~redirect_valid
                    & (discard_q == '0) & (q_pending != '0);

        instruction = out_valid ? head.data : RV_NOP;
        pc_count    = (q_count != '0) ? head.pc : fetch_pc_q;

        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        owed       = '0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            owed = SW'(discard_q) + SW'(q_pending);
            if (imem.imem_rsp_valid && owed != '0) begin
                owed = owed - SW'(1);
            end
            discard_d = CW'(owed);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem.imem_rsp_valid && discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;

    // run_q keeps imem_req_valid low while reset is asserted, independent of fetch_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            run_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc_count;

    instruction_fetch_unit_if imem();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .pc_count       (pc_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Memory model: word at address A is {16'hC0DE, A[15:0]}.
    typedef struct {
        logic [31:0] addr;
        int          cnt;
    } mreq_t;

    mreq_t       pipe[$];
    int          lat = 1;
    int          acc_cnt = 0;
    logic        spur = 1'b0;
    logic        m_acc;
    logic [31:0] m_addr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(posedge clk) begin
        m_acc  = imem.imem_req_valid && imem.imem_req_ready;
        m_addr = imem.imem_req_addr;
        #1;
        if (!rst_n) begin
            pipe.delete();
            acc_cnt = 0;
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = '0;
        end else begin
            foreach (pipe[i]) pipe[i].cnt = pipe[i].cnt - 1;
            if (m_acc) begin
                pipe.push_back('{m_addr, lat - 1});
                acc_cnt++;
            end
            if (pipe.size() > 0 && pipe[0].cnt <= 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = memword(pipe[0].addr);
                void'(pipe.pop_front());
            end else if (spur) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = 32'hBAD0_BAD0;
            end else begin
                imem.imem_rsp_valid = 1'b0;
                imem.imem_rsp_data  = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int maxc);
        for (int i = 0; i < maxc && !out_valid; i++) step();
    endtask

    initial begin
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;

        // Reset values
        repeat (2) step();
        chk("rst_req_valid", imem.imem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instr", instruction, RV_NOP);
        chk("rst_pc_count", pc_count, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_valid", imem.imem_req_valid, 0);

        // Streaming at latency 1
        step();
        chk("a1_req_valid", imem.imem_req_valid, 1);
        chk("a1_req_addr", imem.imem_req_addr, 32'h0);
        step();
        chk("a2_req_addr", imem.imem_req_addr, 32'h4);
        chk("a2_out_valid", out_valid, 0);
        step();
        chk("a3_out_valid", out_valid, 1);
        chk("a3_pc", pc_count, 32'h0);
        chk("a3_instr", instruction, 32'hC0DE_0000);
        chk("a3_req_addr", imem.imem_req_addr, 32'h8);
        step();
        chk("a4_pc", pc_count, 32'h4);
        chk("a4_instr", instruction, 32'hC0DE_0004);
        step();
        chk("a5_pc", pc_count, 32'h8);
        chk("a5_instr", instruction, 32'hC0DE_0008);

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("ar_req_valid", imem.imem_req_valid, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_instr", instruction, RV_NOP);
        chk("ar_pc_count", pc_count, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;

        // Decoder stalled: at most DEPTH requests
        step();
        chk("b1_req_addr", imem.imem_req_addr, 32'h0);
        step();
        chk("b2_req_addr", imem.imem_req_addr, 32'h4);
        repeat (8) step();
        chk("b_req_valid", imem.imem_req_valid, 0);
        chk("b_out_valid", out_valid, 1);
        chk("b_pc", pc_count, 32'h0);
        chk("b_instr", instruction, 32'hC0DE_0000);
        chk("b_accepted", acc_cnt, 2);
        out_ready = 1'b1;
        #1;
        chk("r0_pc", pc_count, 32'h0);
        chk("r0_req_addr", imem.imem_req_addr, 32'h8);
        step();
        chk("r1_pc", pc_count, 32'h4);
        chk("r1_instr", instruction, 32'hC0DE_0004);
        step();
        chk("r2_pc", pc_count, 32'h8);
        chk("r2_instr", instruction, 32'hC0DE_0008);
        step();
        chk("r3_pc", pc_count, 32'hC);
        chk("r3_instr", instruction, 32'hC0DE_000C);
        fetch_en = 1'b0;
        repeat (4) step();
        chk("dr_out_valid", out_valid, 0);
        chk("dr_pc_count", pc_count, 32'h14);
        chk("dr_req_valid", imem.imem_req_valid, 0);

        // Latency 3, redirect with two requests in flight
        lat = 3;
        fetch_en = 1'b1;
        step();
        chk("c1_req_addr", imem.imem_req_addr, 32'h18);
        step();
        chk("c2_req_valid", imem.imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("c3_req_valid", imem.imem_req_valid, 0);
        step();
        chk("c4_req_valid", imem.imem_req_valid, 1);
        chk("c4_req_addr", imem.imem_req_addr, 32'h100);
        wait_out(12);
        chk("c_out_valid", out_valid, 1);
        chk("c_pc", pc_count, 32'h100);
        chk("c_instr", instruction, 32'hC0DE_0100);

        // Redirect together with a response and a handshake; misaligned target
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        #1;
        chk("d_out_valid", out_valid, 0);
        chk("d_instr", instruction, RV_NOP);
        chk("d_req_valid", imem.imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("d1_req_valid", imem.imem_req_valid, 1);
        chk("d1_req_addr", imem.imem_req_addr, 32'h200);
        wait_out(12);
        chk("d_pc", pc_count, 32'h200);
        chk("d_word", instruction, 32'hC0DE_0200);

        // PC wrap from 0xFFFF_FFFC
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("w0_req_addr", imem.imem_req_addr, 32'hFFFF_FFFC);
        step();
        chk("w1_req_valid", imem.imem_req_valid, 1);
        chk("w1_req_addr", imem.imem_req_addr, 32'h0);
        wait_out(12);
        chk("w_pc_top", pc_count, 32'hFFFF_FFFC);
        chk("w_instr_top", instruction, 32'hC0DE_FFFC);
        step();
        chk("w_pc_zero", pc_count, 32'h0);
        chk("w_instr_zero", instruction, 32'hC0DE_0000);

        // fetch_en=0 drains, then a spurious response must be ignored
        fetch_en = 1'b0;
        repeat (8) step();
        chk("g_out_valid", out_valid, 0);
        chk("g_pc_count", pc_count, 32'h8);
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (2) step();
        chk("s_out_valid", out_valid, 0);
        chk("s_pc_count", pc_count, 32'h8);
        chk("s_req_valid", imem.imem_req_valid, 0);
        fetch_en = 1'b1;
        #1;
        chk("s_req_addr", imem.imem_req_addr, 32'h8);
        wait_out(12);
        chk("s_pc", pc_count, 32'h8);
        chk("s_instr", instruction, 32'hC0DE_0008);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
